// File: rtl/encoder8to3_seq.sv
// ----------------------------------------------------------------------------
// encoder8to3_seq
//   Captures a multi-hot 8-bit request vector and returns the index of each
//   set bit as a 3-bit code, one code per accepted READY handshake. The order
//   is highest index first (MSB_FIRST=1) or lowest index first (MSB_FIRST=0).
//   All outputs are registered.
//
// Parameters
//   MSB_FIRST : 1 = emit highest pending index first, 0 = lowest first
//
// Ports
//   CLK   in   rising-edge clock
//   RST_N in   asynchronous active-low reset
//   REQ   in   [7:0] request vector, sampled on an accepted LOAD
//   LOAD  in   capture REQ (accepted only while idle)
//   READY in   consumer takes the current code when VALID=1
//   Y     out  [2:0] index of the current pending bit
//   VALID out  Y holds a valid code
//   BUSY  out  high while codes are being emitted
//   CNT   out  [3:0] number of pending bits not yet accepted (0-8)
//   DONE  out  one-cycle pulse after the last code is accepted
//   ERR   out  one-cycle pulse on an accepted LOAD with REQ=0
// ----------------------------------------------------------------------------
module encoder8to3_seq #(
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] REQ,
    input  logic       LOAD,
    input  logic       READY,
    output logic [2:0] Y,
    output logic       VALID,
    output logic       BUSY,
    output logic [3:0] CNT,
    output logic       DONE,
    output logic       ERR
);

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pend_q,  pend_d;
    logic [2:0] y_q,     y_d;
    logic       valid_q, valid_d;
    logic       busy_q,  busy_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       done_q,  done_d;
    logic       err_q,   err_d;

    logic [7:0] pend_clr;

    // Priority pick: the last match in the scan wins, so scanning upward
    // yields the highest set index and scanning downward the lowest.
    function automatic logic [2:0] pick(input logic [7:0] v);
        logic [2:0] r;
        logic [2:0] idx;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (MSB_FIRST != 0) begin
                idx = 3'(i);
            end else begin
                idx = 3'(7 - i);
            end
            if (v[idx]) begin
                r = idx;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Pending set after removing the code currently presented on Y.
    assign pend_clr = pend_q & ~(8'd1 << y_q);

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        y_d     = y_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (LOAD) begin
                    if (REQ != '0) begin
                        state_d = S_EMIT;
                        pend_d  = REQ;
                        y_d     = pick(REQ);
                        cnt_d   = popcount(REQ);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                // VALID is always high here, so READY alone means acceptance.
                if (READY) begin
                    if (pend_clr == '0) begin
                        state_d = S_IDLE;
                        pend_d  = '0;
                        y_d     = '0;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        pend_d  = pend_clr;
                        y_d     = pick(pend_clr);
                        cnt_d   = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Y     = y_q;
    assign VALID = valid_q;
    assign BUSY  = busy_q;
    assign CNT   = cnt_q;
    assign DONE  = done_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_encoder8to3_seq.sv
// ----------------------------------------------------------------------------
// tb_encoder8to3_seq
//   Two encoder instances share all inputs: index 0 uses MSB_FIRST=1,
//   index 1 uses MSB_FIRST=0. Each has its own scoreboard of expected codes,
//   filled when a LOAD is seen while the model is idle and drained on every
//   VALID/READY handshake.
// ----------------------------------------------------------------------------
module tb_encoder8to3_seq;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b1;
    logic [7:0] REQ   = '0;
    logic       LOAD  = 1'b0;
    logic       READY = 1'b0;

    logic [2:0] y_w     [2];
    logic       valid_w [2];
    logic       busy_w  [2];
    logic [3:0] cnt_w   [2];
    logic       done_w  [2];
    logic       err_w   [2];

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    typedef struct packed {
        logic [2:0] y;
        logic [3:0] cnt;
        logic       last;
    } exp_t;

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    genvar k;
    for (k = 0; k < 2; k++) begin : g_mon
        encoder8to3_seq #(
            .MSB_FIRST(k == 0 ? 1 : 0)
        ) u_dut (
            .CLK   (CLK),
            .RST_N (RST_N),
            .REQ   (REQ),
            .LOAD  (LOAD),
            .READY (READY),
            .Y     (y_w[k]),
            .VALID (valid_w[k]),
            .BUSY  (busy_w[k]),
            .CNT   (cnt_w[k]),
            .DONE  (done_w[k]),
            .ERR   (err_w[k])
        );

        exp_t       sb[$];
        exp_t       head;
        logic       done_exp = 1'b0;
        logic       err_exp  = 1'b0;
        logic       idle;
        logic [3:0] c;

        always @(negedge CLK) begin
            if (!RST_N) begin
                sb.delete();
                done_exp = 1'b0;
                err_exp  = 1'b0;
                check($sformatf("i%0d.rst_VALID", k), 32'(valid_w[k]), 0);
                check($sformatf("i%0d.rst_BUSY", k),  32'(busy_w[k]),  0);
                check($sformatf("i%0d.rst_CNT", k),   32'(cnt_w[k]),   0);
                check($sformatf("i%0d.rst_Y", k),     32'(y_w[k]),     0);
                check($sformatf("i%0d.rst_DONE", k),  32'(done_w[k]),  0);
                check($sformatf("i%0d.rst_ERR", k),   32'(err_w[k]),   0);
            end else begin
                check($sformatf("i%0d.DONE", k),  32'(done_w[k]),  32'(done_exp));
                check($sformatf("i%0d.ERR", k),   32'(err_w[k]),   32'(err_exp));
                check($sformatf("i%0d.VALID", k), 32'(valid_w[k]), 32'(sb.size() != 0));
                check($sformatf("i%0d.BUSY", k),  32'(busy_w[k]),  32'(sb.size() != 0));
                if (sb.size() != 0) begin
                    head = sb[0];
                    check($sformatf("i%0d.Y", k),   32'(y_w[k]),   32'(head.y));
                    check($sformatf("i%0d.CNT", k), 32'(cnt_w[k]), 32'(head.cnt));
                end else begin
                    check($sformatf("i%0d.CNT_idle", k), 32'(cnt_w[k]), 0);
                end

                idle     = (sb.size() == 0);
                done_exp = 1'b0;
                err_exp  = 1'b0;
                if (!idle && READY) begin
                    head     = sb.pop_front();
                    done_exp = head.last;
                end
                if (idle && LOAD) begin
                    if (REQ == 8'h00) begin
                        err_exp = 1'b1;
                    end else begin
                        c = '0;
                        for (int i = 0; i < 8; i++) c = c + {3'b000, REQ[i]};
                        if (k == 0) begin
                            for (int i = 7; i >= 0; i--) begin
                                if (REQ[i]) begin
                                    sb.push_back('{y: 3'(i), cnt: c, last: (c == 4'd1)});
                                    c = c - 4'd1;
                                end
                            end
                        end else begin
                            for (int i = 0; i < 8; i++) begin
                                if (REQ[i]) begin
                                    sb.push_back('{y: 3'(i), cnt: c, last: (c == 4'd1)});
                                    c = c - 4'd1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // Inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        LOAD = 1'b1;
        REQ  = v;
        tick();
        LOAD = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (done_w[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_within_budget", 32'(seen), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 RST_N = 1'b0;
        repeat (2) tick();
        RST_N = 1'b1;

        // Basic transfer with continuous READY.
        READY = 1'b1;
        tick();
        load(8'b1010_0100);
        wait_done(20);

        // LOAD in the DONE cycle is accepted.
        load(8'h01);
        wait_done(20);

        // Back-pressure: READY low for 4 cycles.
        tick();
        READY = 1'b0;
        load(8'h81);
        repeat (4) tick();
        READY = 1'b1;
        wait_done(20);

        // Empty request, then LOADs ignored while emitting.
        tick();
        load(8'h00);
        tick();
        tick();
        READY = 1'b0;
        load(8'h24);
        tick();
        load(8'h10);
        load(8'h00);
        tick();
        READY = 1'b1;
        wait_done(20);

        // Full vector.
        tick();
        load(8'hFF);
        wait_done(20);

        // Random vectors with random back-pressure.
        for (int t = 0; t < 6; t++) begin
            bit seen;
            tick();
            load(8'($urandom_range(1, 255)));
            seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                READY = 1'($urandom_range(0, 1));
                tick();
                if (done_w[0]) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("rand_done_within_budget", 32'(seen), 1);
            READY = 1'b1;
        end

        // Reset in the middle of an 8-code transfer.
        tick();
        READY = 1'b1;
        load(8'hFF);
        repeat (3) tick();
        #1 RST_N = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("async_rst_VALID", 32'(valid_w[i]), 0);
            check("async_rst_BUSY",  32'(busy_w[i]),  0);
            check("async_rst_CNT",   32'(cnt_w[i]),   0);
            check("async_rst_Y",     32'(y_w[i]),     0);
            check("async_rst_DONE",  32'(done_w[i]),  0);
        end
        repeat (2) tick();
        RST_N = 1'b1;
        load(8'h01);
        wait_done(20);

        repeat (4) tick();
        check("sb0_empty", 32'(g_mon[0].sb.size()), 0);
        check("sb1_empty", 32'(g_mon[1].sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
